// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the single-bus datapath: ALU opcodes,
// multiply/divide sequencer states and small helpers.
package bus_datapath_pkg;

    // ALU operation codes (4 bits); 12..15 are reserved and give 0 on z_in
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_NEG = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    // Multi-cycle sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/bus_datapath_seq_muldiv.sv
// Sequential signed multiplier (shift-add) and restoring divider.
// Ports: clk/clr, start_i/op_i/a_i/b_i request, busy_o/done_o status,
//        wr_o + res_hi_o/res_lo_o result write strobe for Z.
module seq_muldiv
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wr_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             neg_q;
    logic             rneg_q;
    logic             dz_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shr_q;

    logic             go;
    logic             last;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] shr_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign go   = start_i && (state_q == ST_IDLE) && is_muldiv(op_i);
    assign last = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (go) state_d = ST_RUN;
            ST_RUN:  if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // One iteration of either algorithm on the magnitude registers.
    // Multiply: acc:shr is the partial product, shr starts as |B|.
    // Divide: acc is the partial remainder, shr shifts dividend out
    // and quotient bits in.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, (shr_q[0] ? mag_q : '0)};
        shifted = {acc_q, shr_q[WIDTH-1]};
        trial   = shifted - {1'b0, mag_q};
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                acc_n = trial[WIDTH-1:0];
                shr_n = {shr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted[WIDTH-1:0];
                shr_n = {shr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = sum[WIDTH:1];
            shr_n = {sum[0], shr_q[WIDTH-1:1]};
        end
    end

    // Sign correction on the final iteration's output
    always_comb begin
        prod = {acc_n, shr_n};
        if (neg_q) prod = -prod;
        if (!is_div_q) begin
            res_hi_o = prod[2*WIDTH-1:WIDTH];
            res_lo_o = prod[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi_o = a_q;
            res_lo_o = '1;
        end else begin
            res_hi_o = rneg_q ? -acc_n : acc_n;
            res_lo_o = neg_q ? -shr_n : shr_n;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            mag_q    <= '0;
            acc_q    <= '0;
            shr_q    <= '0;
        end else if (go) begin
            cnt_q    <= '0;
            is_div_q <= (op_i == OP_DIV);
            neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            rneg_q   <= a_i[WIDTH-1];
            dz_q     <= (b_i == '0);
            a_q      <= a_i;
            acc_q    <= '0;
            if (op_i == OP_DIV) begin
                mag_q <= mag(b_i);
                shr_q <= mag(a_i);
            end else begin
                mag_q <= mag(a_i);
                shr_q <= mag(b_i);
            end
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_n;
            shr_q <= shr_n;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign wr_o   = (state_q == ST_RUN) && last;

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath: register file, Y, Z, HI, LO on one shared bus.
// Ports: per-register reg_in/reg_out, unit in/out enables, ext_data
//        source, alu_op/start control; busy/done/bus_err/bus_data/Z out.
module bus_datapath_seq
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter bit R0_BA = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NREGS-1:0] reg_in,
    input  logic [NREGS-1:0] reg_out,
    input  logic             ba_out,
    input  logic             y_in,
    input  logic             z_in,
    input  logic             zhi_out,
    input  logic             zlo_out,
    input  logic             hi_in,
    input  logic             lo_in,
    input  logic             hi_out,
    input  logic             lo_out,
    input  logic             ext_out,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [3:0]       alu_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             bus_err,
    output logic [WIDTH-1:0] bus_data,
    output logic [WIDTH-1:0] zhi_data,
    output logic [WIDTH-1:0] zlo_data
);

    localparam int SW   = $clog2(WIDTH);
    localparam int NSRC = NREGS + 5;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;

    logic [NSRC-1:0]  srcs;
    logic [WIDTH-1:0] bus_v;
    logic             r0_mask;
    logic             ld_ok;

    logic [SW-1:0]    shamt;
    logic [SW:0]      inv_sh;
    logic [WIDTH-1:0] alu_res;

    logic             md_wr;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    // Bus conflict: more than one bit set in the source vector
    assign srcs    = {reg_out, hi_out, lo_out, zhi_out, zlo_out, ext_out};
    assign bus_err = |(srcs & (srcs - NSRC'(1)));
    assign ld_ok   = !bus_err;
    assign r0_mask = R0_BA && ba_out;

    always_comb begin
        bus_v = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_out[i] && !(i == 0 && r0_mask)) bus_v |= regs_q[i];
        end
        if (hi_out)  bus_v |= hi_q;
        if (lo_out)  bus_v |= lo_q;
        if (zhi_out) bus_v |= zhi_q;
        if (zlo_out) bus_v |= zlo_q;
        if (ext_out) bus_v |= ext_data;
    end

    assign bus_data = bus_err ? '0 : bus_v;

    // Shift/rotate amount is taken from the same bus operand being shifted
    assign shamt  = bus_data[SW-1:0];
    assign inv_sh = (SW+1)'(WIDTH) - {1'b0, shamt};

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            OP_ADD: alu_res = y_q + bus_data;
            OP_SUB: alu_res = y_q - bus_data;
            OP_AND: alu_res = y_q & bus_data;
            OP_OR:  alu_res = y_q | bus_data;
            OP_SHR: alu_res = bus_data >> shamt;
            OP_SHL: alu_res = bus_data << shamt;
            OP_ROR: alu_res = (bus_data >> shamt) | (bus_data << inv_sh);
            OP_ROL: alu_res = (bus_data << shamt) | (bus_data >> inv_sh);
            OP_NEG: alu_res = -bus_data;
            OP_NOT: alu_res = ~bus_data;
            default: alu_res = '0;
        endcase
    end

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .clr      (clr),
        .start_i  (start && ld_ok),
        .op_i     (alu_op),
        .a_i      (y_q),
        .b_i      (bus_data),
        .busy_o   (busy),
        .done_o   (done),
        .wr_o     (md_wr),
        .res_hi_o (md_hi),
        .res_lo_o (md_lo)
    );

    // Sequencer write wins; single-cycle loads are locked out while busy
    always_comb begin
        zhi_d = zhi_q;
        zlo_d = zlo_q;
        if (md_wr) begin
            zhi_d = md_hi;
            zlo_d = md_lo;
        end else if (z_in && !busy) begin
            zhi_d = '0;
            zlo_d = alu_res;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in[i] && ld_ok) regs_q[i] <= bus_data;
            end
            if (y_in && ld_ok)  y_q  <= bus_data;
            if (hi_in && ld_ok) hi_q <= bus_data;
            if (lo_in && ld_ok) lo_q <= bus_data;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
        end
    end

    assign zhi_data = zhi_q;
    assign zlo_data = zlo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Self-checking bench for bus_datapath_seq (WIDTH=32, NREGS=16).
// Random stimulus checked against a plain-arithmetic reference model.
module tb_bus_datapath_seq;
    import bus_datapath_pkg::*;

    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic [N-1:0]  reg_in, reg_out;
    logic          ba_out, y_in, z_in, zhi_out, zlo_out;
    logic          hi_in, lo_in, hi_out, lo_out, ext_out;
    logic [W-1:0]  ext_data;
    logic [3:0]    alu_op;
    logic          start;
    logic          busy, done, bus_err;
    logic [W-1:0]  bus_data, zhi_data, zlo_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_r [N];
    logic [W-1:0] m_y, m_zhi, m_zlo, m_hi, m_lo;

    bus_datapath_seq #(.WIDTH(W), .NREGS(N), .R0_BA(1'b1)) dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
        .ba_out(ba_out), .y_in(y_in), .z_in(z_in), .zhi_out(zhi_out),
        .zlo_out(zlo_out), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out),
        .lo_out(lo_out), .ext_out(ext_out), .ext_data(ext_data),
        .alu_op(alu_op), .start(start), .busy(busy), .done(done),
        .bus_err(bus_err), .bus_data(bus_data), .zhi_data(zhi_data),
        .zlo_data(zlo_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int s;
        logic [W-1:0] r;
        s = int'(b % W);
        r = b;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_SHR: return b >> s;
            OP_SHL: return b << s;
            OP_ROR: begin
                for (int k = 0; k < s; k++) r = {r[0], r[W-1:1]};
                return r;
            end
            OP_ROL: begin
                for (int k = 0; k < s; k++) r = {r[W-2:0], r[W-1]};
                return r;
            end
            OP_NEG: return 0 - b;
            OP_NOT: return ~b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2*W-1:0] ref_muldiv(input logic [3:0] op,
                                                   input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) begin
            p = sa * sb;
            return p;
        end
        if (b == 0) return {a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_r[i] = '0;
        m_y = '0; m_zhi = '0; m_zlo = '0; m_hi = '0; m_lo = '0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        reg_in = '0; reg_out = '0; ba_out = 0; y_in = 0; z_in = 0;
        zhi_out = 0; zlo_out = 0; hi_in = 0; lo_in = 0; hi_out = 0;
        lo_out = 0; ext_out = 0; ext_data = '0; alu_op = '0; start = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input int i, input logic [W-1:0] v);
        idle_in();
        ext_out = 1; ext_data = v; reg_in[i] = 1'b1;
        tick();
        idle_in();
        m_r[i] = v;
    endtask

    task automatic load_y(input logic [W-1:0] v);
        idle_in();
        ext_out = 1; ext_data = v; y_in = 1;
        tick();
        idle_in();
        m_y = v;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int edges,
                          output int bcnt);
        load_y(a);
        ext_out = 1; ext_data = b; alu_op = op; start = 1;
        tick();
        idle_in();
        edges = 1;
        bcnt = busy ? 1 : 0;
        while (!done && edges < 200) begin
            tick();
            edges++;
            if (busy) bcnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) load_reg(i, $urandom);
        ext_out = 1; ext_data = $urandom; hi_in = 1; tick(); idle_in();
        ext_out = 1; ext_data = $urandom; lo_in = 1; tick(); idle_in();
        load_y($urandom);
        ext_out = 1; ext_data = $urandom; alu_op = OP_NOT; z_in = 1;
        tick(); idle_in();
        #2 clr = 0;
        model_clear();
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b want 0 0", busy, done);
        end
        n_checks++;
        if (zhi_data !== m_zhi || zlo_data !== m_zlo) begin
            n_fail++;
            $display("FAIL reset_z: got %h_%h want %h_%h",
                     zhi_data, zlo_data, m_zhi, m_zlo);
        end
        for (int i = 0; i < N; i++) begin
            reg_out = '0; reg_out[i] = 1'b1;
            #1;
            n_checks++;
            if (bus_data !== m_r[i]) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h want %h", i, bus_data, m_r[i]);
            end
        end
        idle_in(); hi_out = 1; #1; v = bus_data;
        idle_in(); lo_out = 1; #1;
        n_checks++;
        if (v !== m_hi || bus_data !== m_lo) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h %h want %h %h", v, bus_data, m_hi, m_lo);
        end
        idle_in();
        #2 clr = 1;
        tick();
    endtask

    task automatic test_add();
        load_reg(3, 32'd5);
        reg_out[3] = 1; y_in = 1; tick(); idle_in();
        m_y = m_r[3];
        ext_out = 1; ext_data = 32'd3; alu_op = OP_ADD; z_in = 1;
        tick(); idle_in();
        m_zlo = ref_alu(OP_ADD, m_y, 32'd3); m_zhi = '0;
        n_checks++;
        if (zlo_data !== 32'h8 || zhi_data !== 32'h0) begin
            n_fail++;
            $display("FAIL add_spec: got %h_%h want 00000000_00000008", zhi_data, zlo_data);
        end
        n_checks++;
        if (zlo_data !== m_zlo) begin
            n_fail++;
            $display("FAIL add_model: got %h want %h", zlo_data, m_zlo);
        end
    endtask

    task automatic test_alu_random();
        logic [3:0] op;
        logic [W-1:0] a, b;
        for (int it = 0; it < 40; it++) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_MUL || op == OP_DIV) op = 4'($urandom_range(0, 9));
            a = $urandom;
            b = (it % 2 == 0) ? W'($urandom_range(0, 63)) : W'($urandom);
            load_y(a);
            ext_out = 1; ext_data = b; alu_op = op; z_in = 1;
            tick(); idle_in();
            m_zlo = ref_alu(op, a, b); m_zhi = '0;
            n_checks++;
            if (zlo_data !== m_zlo || zhi_data !== m_zhi) begin
                n_fail++;
                $display("FAIL alu op=%0d a=%h b=%h: got %h_%h want %h_%h",
                         op, a, b, zhi_data, zlo_data, m_zhi, m_zlo);
            end
        end
    endtask

    task automatic test_muldiv();
        int e, bc;
        logic [3:0] ops [4];
        logic [W-1:0] as [4], bs [4], hs [4], ls [4];
        logic [2*W-1:0] exp;
        logic [3:0] op;
        logic [W-1:0] a, b;
        ops[0] = OP_MUL; as[0] = 32'hFFFFFFFD; bs[0] = 32'd7;
        hs[0] = 32'hFFFFFFFF; ls[0] = 32'hFFFFFFEB;
        ops[1] = OP_DIV; as[1] = 32'hFFFFFFF9; bs[1] = 32'd2;
        hs[1] = 32'hFFFFFFFF; ls[1] = 32'hFFFFFFFD;
        ops[2] = OP_DIV; as[2] = 32'd9; bs[2] = 32'd0;
        hs[2] = 32'h00000009; ls[2] = 32'hFFFFFFFF;
        ops[3] = OP_DIV; as[3] = 32'h80000000; bs[3] = 32'hFFFFFFFF;
        hs[3] = 32'h00000000; ls[3] = 32'h80000000;
        for (int t = 0; t < 4; t++) begin
            run_op(ops[t], as[t], bs[t], e, bc);
            n_checks++;
            if (e !== W + 1 || bc !== W + 1) begin
                n_fail++;
                $display("FAIL md_timing%0d: done edge %0d busy %0d want %0d",
                         t, e, bc, W + 1);
            end
            n_checks++;
            if (zhi_data !== hs[t] || zlo_data !== ls[t]) begin
                n_fail++;
                $display("FAIL md_dir%0d: got %h_%h want %h_%h",
                         t, zhi_data, zlo_data, hs[t], ls[t]);
            end
            m_zhi = hs[t]; m_zlo = ls[t];
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL md_end%0d: done=%b busy=%b want 0 0", t, done, busy);
            end
        end
        for (int it = 0; it < 10; it++) begin
            op = (it % 2 == 0) ? OP_MUL : OP_DIV;
            a = $urandom;
            b = (it % 3 == 0) ? W'($signed(W'($urandom_range(0, 31))) - 16) : W'($urandom);
            if (it == 7) b = '0;
            run_op(op, a, b, e, bc);
            exp = ref_muldiv(op, a, b);
            m_zhi = exp[2*W-1:W]; m_zlo = exp[W-1:0];
            n_checks++;
            if (e !== W + 1 || zhi_data !== m_zhi || zlo_data !== m_zlo) begin
                n_fail++;
                $display("FAIL md_rand op=%0d a=%h b=%h: edge %0d got %h_%h want %h_%h",
                         op, a, b, e, zhi_data, zlo_data, m_zhi, m_zlo);
            end
            tick();
        end
        load_y(32'd4);
        ext_out = 1; ext_data = 32'd4; alu_op = OP_ADD; start = 1;
        tick(); idle_in();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_nonmd: busy=%b want 0", busy);
        end
    endtask

    task automatic test_bus_conflict();
        logic [W-1:0] x;
        load_reg(1, $urandom);
        load_reg(2, $urandom);
        x = $urandom;
        reg_out[1] = 1; ext_out = 1; ext_data = x; reg_in[2] = 1;
        #1;
        n_checks++;
        if (bus_err !== 1'b1 || bus_data !== '0) begin
            n_fail++;
            $display("FAIL conflict_bus: err=%b data=%h want 1 0", bus_err, bus_data);
        end
        tick(); idle_in();
        reg_out[2] = 1; #1;
        n_checks++;
        if (bus_err !== 1'b0 || bus_data !== m_r[2]) begin
            n_fail++;
            $display("FAIL conflict_r2: err=%b got %h want %h", bus_err, bus_data, m_r[2]);
        end
        idle_in();
        load_y(32'd3);
        hi_out = 1; ext_out = 1; ext_data = 32'd5; alu_op = OP_MUL; start = 1;
        tick(); idle_in();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_start: busy=%b want 0", busy);
        end
        load_reg(0, 32'h1234);
        reg_out[0] = 1; ba_out = 1; #1;
        n_checks++;
        if (bus_data !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_ba: got %h want 00000000", bus_data);
        end
        ba_out = 0; #1;
        n_checks++;
        if (bus_data !== m_r[0]) begin
            n_fail++;
            $display("FAIL r0_plain: got %h want %h", bus_data, m_r[0]);
        end
        idle_in();
        load_reg(5, $urandom);
        reg_in[5] = 1; tick(); idle_in();
        m_r[5] = '0;
        reg_out[5] = 1; #1;
        n_checks++;
        if (bus_data !== m_r[5]) begin
            n_fail++;
            $display("FAIL nosrc_load: got %h want %h", bus_data, m_r[5]);
        end
        idle_in();
    endtask

    task automatic test_hi_lo();
        logic [W-1:0] v;
        load_reg(9, $urandom);
        reg_out[9] = 1; hi_in = 1; tick(); idle_in();
        m_hi = m_r[9];
        m_lo = $urandom;
        ext_out = 1; ext_data = m_lo; lo_in = 1; tick(); idle_in();
        hi_out = 1; #1; v = bus_data; idle_in();
        lo_out = 1; #1;
        n_checks++;
        if (v !== m_hi || bus_data !== m_lo) begin
            n_fail++;
            $display("FAIL hilo: got %h %h want %h %h", v, bus_data, m_hi, m_lo);
        end
        idle_in(); zhi_out = 1; #1; v = bus_data; idle_in();
        zlo_out = 1; #1;
        n_checks++;
        if (v !== m_zhi || bus_data !== m_zlo) begin
            n_fail++;
            $display("FAIL zbus: got %h %h want %h %h", v, bus_data, m_zhi, m_zlo);
        end
        idle_in();
    endtask

    task automatic test_back_to_back();
        int e;
        logic [W-1:0] a, b, zl, zh;
        logic [2*W-1:0] exp;
        a = $urandom; b = $urandom;
        load_y(a);
        ext_out = 1; ext_data = b; alu_op = OP_MUL; start = 1;
        tick(); idle_in();
        exp = ref_muldiv(OP_MUL, a, b);
        zl = m_zlo; zh = m_zhi;
        e = 1;
        while (!done && e < 200) begin
            idle_in();
            if (e == 4) begin
                ext_out = 1; ext_data = 32'h55AA; alu_op = OP_DIV;
                start = 1; reg_in[7] = 1; y_in = 1;
                m_r[7] = 32'h55AA;
            end
            if (e == 6) begin
                ext_out = 1; ext_data = 32'd77; alu_op = OP_ADD; z_in = 1;
            end
            tick();
            e++;
            if (e == 7) begin
                n_checks++;
                if (zlo_data !== zl || zhi_data !== zh) begin
                    n_fail++;
                    $display("FAIL zin_busy: got %h_%h want %h_%h",
                             zhi_data, zlo_data, zh, zl);
                end
            end
        end
        idle_in();
        m_zhi = exp[2*W-1:W]; m_zlo = exp[W-1:0];
        n_checks++;
        if (e !== W + 1 || zhi_data !== m_zhi || zlo_data !== m_zlo) begin
            n_fail++;
            $display("FAIL busy_start_ign: edge %0d got %h_%h want %0d %h_%h",
                     e, zhi_data, zlo_data, W + 1, m_zhi, m_zlo);
        end
        tick();
        reg_out[7] = 1; #1;
        n_checks++;
        if (bus_data !== m_r[7]) begin
            n_fail++;
            $display("FAIL reg_during_run: got %h want %h", bus_data, m_r[7]);
        end
        idle_in();
        m_y = 32'h55AA;
    endtask

    task automatic test_abort();
        int e, bc, dseen;
        logic [W-1:0] a, b;
        logic [2*W-1:0] exp;
        load_y($urandom);
        ext_out = 1; ext_data = $urandom; alu_op = OP_MUL; start = 1;
        tick(); idle_in();
        repeat (10) tick();
        #2 clr = 0;
        model_clear();
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || zhi_data !== m_zhi || zlo_data !== m_zlo) begin
            n_fail++;
            $display("FAIL abort: busy=%b done=%b z=%h_%h want 0 0 0_0",
                     busy, done, zhi_data, zlo_data);
        end
        #3 clr = 1;
        dseen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) dseen++;
        end
        n_checks++;
        if (dseen !== 0) begin
            n_fail++;
            $display("FAIL abort_done: %0d done pulses want 0", dseen);
        end
        a = $urandom; b = $urandom;
        run_op(OP_DIV, a, b, e, bc);
        exp = ref_muldiv(OP_DIV, a, b);
        m_zhi = exp[2*W-1:W]; m_zlo = exp[W-1:0];
        n_checks++;
        if (e !== W + 1 || zhi_data !== m_zhi || zlo_data !== m_zlo) begin
            n_fail++;
            $display("FAIL restart: edge %0d got %h_%h want %0d %h_%h",
                     e, zhi_data, zlo_data, W + 1, m_zhi, m_zlo);
        end
        tick();
    endtask

    initial begin
        idle_in();
        model_clear();
        clr = 0;
        repeat (2) @(posedge clk);
        #3 clr = 1;
        tick();
        test_reset();
        test_add();
        test_alu_random();
        test_muldiv();
        test_bus_conflict();
        test_hi_lo();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
Parametrised single-bus processor datapath, the successor to the fixed 16x32 datapath. It contains NREGS general registers, Y, Z (hi/lo), HI and LO, all joined by one shared bus with one-hot source select and conflict detection. Single-cycle ALU ops load Z directly. A sequential shift-add multiplier and restoring divider add a start/busy/done handshake. The control unit drives every select and enable line.

Parameters:
WIDTH, 32, data/bus width in bits (power of 2, >=8)
NREGS, 16, number of general registers (2..32)
R0_BA, 1, when 1, R0 reads as 0 while ba_out=1

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous, active-low reset
reg_in  in  NREGS  per-register load enable from bus
reg_out  in  NREGS  per-register bus source select
ba_out  in  1  base-address mode for R0
y_in  in  1  load Y from bus
z_in  in  1  load Z with single-cycle ALU result
zhi_out / zlo_out  in  1 each  Z halves drive bus
hi_in / lo_in  in  1 each  load HI/LO from bus
hi_out / lo_out  in  1 each  HI/LO drive bus
ext_out  in  1  ext_data drives bus (MDR/port/constant)
ext_data  in  WIDTH  external bus source
alu_op  in  4  operation code (package constants)
start  in  1  begin MUL/DIV, one-cycle pulse
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: Z holds MUL/DIV result
bus_err  out  1  more than one bus source asserted (combinational)
bus_data  out  WIDTH  current bus value
zhi_data / zlo_data  out  WIDTH  Z register contents

Behaviour:
- Reset (clr=0, async): all registers, Y, Z, HI and LO go to 0. FSM goes to IDLE. busy=0, done=0.
- Bus source selection:
  - Sources are reg_out[*], hi_out, lo_out, zhi_out, zlo_out and ext_out.
  - Exactly one asserted: bus = that source.
  - None asserted: bus = 0.
  - Two or more asserted: bus = 0, bus_err=1, and every bus-loaded destination is suppressed that cycle (reg_in, y_in, hi_in, lo_in, start).
- R0_BA=1 with ba_out=1: R0's bus contribution is 0. R0 storage is unaffected.
- A destination load enable with no bus source loads 0.
- Single-cycle ops, A=Y, B=bus:
  - ADD, SUB, AND, OR, NEG (-B), NOT (~B).
  - SHR (logical), SHL, ROR, ROL, with shift amount = B[log2(WIDTH)-1:0]; note this makes the shifted value and the shift amount the same B.
  - Results are modulo 2^WIDTH.
  - z_in: ZLO <= result and ZHI <= 0 at the edge.
  - z_in is ignored while busy=1.
- Multi-cycle ops (MUL, DIV), signed two's complement:
  - start with alu_op=MUL/DIV while IDLE captures A=Y and B=bus.
  - FSM: IDLE -> RUN (exactly WIDTH cycles, counter 0..WIDTH-1) -> DONE (1 cycle) -> IDLE.
  - busy=1 in RUN and DONE.
  - On the edge entering DONE, Z is written. done=1 for the DONE cycle only.
  - Result is therefore visible WIDTH+1 edges after the start edge.
  - MUL: {ZHI,ZLO} = full 2*WIDTH-bit signed product.
  - DIV: ZLO = quotient truncated toward zero; ZHI = remainder with the dividend's sign.
  - Divide by zero: ZLO = all ones, ZHI = dividend. No trap.
  - Most-negative / -1: ZLO = most-negative, ZHI = 0.
- Edge cases:
  - start while busy, or start with a non-MUL/DIV op: ignored.
  - Register loads from the bus continue normally during RUN.
  - Reset mid-operation: immediate IDLE, Z=0, no done pulse.

Decomposition:
- Package bus_datapath_pkg holds:
  - alu_op codes: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, ROR=6, ROL=7, NEG=8, NOT=9, MUL=10, DIV=11; 12-15 reserved (z_in loads 0).
  - FSM state encoding: IDLE, RUN, DONE.
- Sub-module seq_muldiv (parameter WIDTH): holds the iteration counter, partial product / remainder shift registers, sign correction and handshake. Top level holds the register file, bus mux/conflict check and single-cycle ALU.

Test Plan:
- Reset: assert clr=0 mid-stream -> all registers, Z, bus_data = 0; busy=0, done=0.
- ADD: ext_data=5 into R3, R3->Y; ext_data=3 on bus, alu_op=ADD, z_in -> zlo_data=0x00000008, zhi_data=0.
- MUL: Y=0xFFFFFFFD (-3), bus=7, start -> busy high 33 cycles; done pulses 33 edges after start; ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB.
- DIV:
  - Y=-7, bus=2 -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF.
  - Y=9, bus=0 -> ZLO=0xFFFFFFFF, ZHI=0x00000009.
- Bus conflict and base-address: reg_out[1] and ext_out together with reg_in[2] -> bus_err=1, bus_data=0, R2 unchanged. R0=0x1234 with reg_out[0], ba_out=1 -> bus_data=0.
- Abort and restart: start MUL, pull clr low at RUN cycle 10 -> busy=0, Z=0, no done; a second start after reset completes normally. A start during busy is ignored.
